// File: rtl/streaming_transpose_pkg.sv
// streaming_transpose_pkg
// Shared definitions for the matrix datapath blocks:
//   - per-bank state encodings (exposed on the transposer debug port)
//   - elem_idx(): LSB position of element (r,c) in a row-major flattened
//     ROWS x COLS x WIDTH vector
//   - cnt_w(): counter width for a 0..n-1 index (at least 1 bit)
package streaming_transpose_pkg;

  localparam logic [1:0] BANK_EMPTY    = 2'd0;
  localparam logic [1:0] BANK_FILLING  = 2'd1;
  localparam logic [1:0] BANK_FULL     = 2'd2;
  localparam logic [1:0] BANK_DRAINING = 2'd3;

  function automatic int unsigned elem_idx(input int unsigned r,
                                           input int unsigned c,
                                           input int unsigned cols,
                                           input int unsigned width);
    return (r * cols + c) * width;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/streaming_transpose_bank.sv
// transpose_bank
// One ROWS x COLS register bank of WIDTH-bit elements.
// Ports:
//   clk, rst       clock, asynchronous active-high reset (clears storage)
//   i_we           write one row this cycle
//   i_row_idx      row being written
//   i_row_data     row data, element c at [c*WIDTH +: WIDTH]
//   i_col_idx      column to read
//   o_col          column data (combinational), element r at [r*WIDTH +: WIDTH]
module transpose_bank
  import streaming_transpose_pkg::*;
#(
  parameter int ROWS  = 3,
  parameter int COLS  = 4,
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_we,
  input  logic [cnt_w(ROWS)-1:0]    i_row_idx,
  input  logic [COLS*WIDTH-1:0]     i_row_data,
  input  logic [cnt_w(COLS)-1:0]    i_col_idx,
  output logic [ROWS*WIDTH-1:0]     o_col
);

  localparam int RW = cnt_w(ROWS);
  localparam int CW = cnt_w(COLS);

  logic [ROWS*COLS*WIDTH-1:0] r_mem;
  logic [ROWS*WIDTH-1:0]      w_col;

  // Row write: decode the row index against constant positions so every
  // select is static.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
    end else if (i_we) begin
      for (int r = 0; r < ROWS; r++) begin
        if (i_row_idx == RW'(r)) begin
          for (int c = 0; c < COLS; c++) begin
            r_mem[elem_idx(r, c, COLS, WIDTH) +: WIDTH] <= i_row_data[c*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  // Column read: plain mux over registered storage.
  always_comb begin
    w_col = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (i_col_idx == CW'(c)) begin
          w_col[r*WIDTH +: WIDTH] = r_mem[elem_idx(r, c, COLS, WIDTH) +: WIDTH];
        end
      end
    end
  end

  assign o_col = w_col;

endmodule

// File: rtl/streaming_transpose.sv
// streaming_transpose
// Double-buffered matrix transposer. Takes a ROWS x COLS matrix one row per
// transfer and emits its transpose one column per transfer. Two banks
// ping-pong so one matrix loads while the other drains.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_row/in_valid/in_ready     input row stream, element c at [c*WIDTH +: WIDTH]
//   out_col/out_valid/out_ready  output column stream, element r at [r*WIDTH +: WIDTH]
//   out_last          high with the final column (c = COLS-1) of a matrix
//   o_dbg_bank_state  {bank1, bank0} state: EMPTY/FILLING/FULL/DRAINING
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready and out_valid come only from registered flags (no combinational
// path from in_valid or out_ready); out_col/out_valid hold while stalled.
module streaming_transpose
  import streaming_transpose_pkg::*;
#(
  parameter int ROWS  = 3,
  parameter int COLS  = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COLS*WIDTH-1:0]  in_row,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ROWS*WIDTH-1:0]  out_col,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [3:0]             o_dbg_bank_state
);

  localparam int RW = cnt_w(ROWS);
  localparam int CW = cnt_w(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic [1:0]    r_full;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [RW-1:0] r_row_cnt;
  logic [CW-1:0] r_col_cnt;

  logic                  w_in_ready;
  logic                  w_wr_fire;
  logic                  w_wr_done;
  logic                  w_out_valid;
  logic                  w_rd_fire;
  logic                  w_rd_done;
  logic [1:0]            w_set;
  logic [1:0]            w_clr;
  logic [ROWS*WIDTH-1:0] w_col0;
  logic [ROWS*WIDTH-1:0] w_col1;
  logic [3:0]            w_dbg;

  assign w_in_ready  = !r_full[r_wr_bank];
  assign w_wr_fire   = in_valid && w_in_ready;
  assign w_wr_done   = w_wr_fire && (r_row_cnt == ROW_LAST);

  assign w_out_valid = r_full[r_rd_bank];
  assign w_rd_fire   = w_out_valid && out_ready;
  assign w_rd_done   = w_rd_fire && (r_col_cnt == COL_LAST);

  // Set and clear never target the same bank (writing needs a not-full
  // bank, reading needs a full one), so both can apply in one cycle.
  assign w_set = {w_wr_done &  r_wr_bank, w_wr_done & ~r_wr_bank};
  assign w_clr = {w_rd_done &  r_rd_bank, w_rd_done & ~r_rd_bank};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_row_cnt <= '0;
      r_col_cnt <= '0;
    end else begin
      r_full <= (r_full | w_set) & ~w_clr;
      if (w_wr_fire) begin
        if (w_wr_done) begin
          r_row_cnt <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_row_cnt <= r_row_cnt + RW'(1);
        end
      end
      if (w_rd_fire) begin
        if (w_rd_done) begin
          r_col_cnt <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_col_cnt <= r_col_cnt + CW'(1);
        end
      end
    end
  end

  transpose_bank #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) u_bank0 (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_wr_fire & ~r_wr_bank),
    .i_row_idx  (r_row_cnt),
    .i_row_data (in_row),
    .i_col_idx  (r_col_cnt),
    .o_col      (w_col0)
  );

  transpose_bank #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) u_bank1 (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_wr_fire & r_wr_bank),
    .i_row_idx  (r_row_cnt),
    .i_row_data (in_row),
    .i_col_idx  (r_col_cnt),
    .o_col      (w_col1)
  );

  // Per-bank state, derived from flags, pointers and counters.
  always_comb begin
    w_dbg = '0;
    for (int b = 0; b < 2; b++) begin
      if (r_full[b]) begin
        w_dbg[b*2 +: 2] = (r_rd_bank == 1'(b) && r_col_cnt != '0) ? BANK_DRAINING : BANK_FULL;
      end else begin
        w_dbg[b*2 +: 2] = (r_wr_bank == 1'(b) && r_row_cnt != '0) ? BANK_FILLING : BANK_EMPTY;
      end
    end
  end

  assign in_ready         = w_in_ready;
  assign out_valid        = w_out_valid;
  assign out_col          = r_rd_bank ? w_col1 : w_col0;
  assign out_last         = w_out_valid && (r_col_cnt == COL_LAST);
  assign o_dbg_bank_state = w_dbg;

endmodule

// File: tb/tb_streaming_transpose.sv
module tb_streaming_transpose;

  localparam int RA = 3, CA = 4, WA = 8;
  localparam int RB = 2, CB = 5, WB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default 3x4x8
  logic                rst_a;
  logic [CA*WA-1:0]    a_in_row;
  logic                a_in_valid, a_in_ready;
  logic [RA*WA-1:0]    a_out_col;
  logic                a_out_valid, a_out_ready, a_out_last;
  logic [3:0]          a_dbg;

  // DUT B: 2x5x16
  logic                rst_b;
  logic [CB*WB-1:0]    b_in_row;
  logic                b_in_valid, b_in_ready;
  logic [RB*WB-1:0]    b_out_col;
  logic                b_out_valid, b_out_ready, b_out_last;
  logic [3:0]          b_dbg;

  streaming_transpose #(.ROWS(RA), .COLS(CA), .WIDTH(WA)) dut_a (
    .clk(clk), .rst(rst_a), .in_row(a_in_row), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_col(a_out_col), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_last(a_out_last),
    .o_dbg_bank_state(a_dbg)
  );

  streaming_transpose #(.ROWS(RB), .COLS(CB), .WIDTH(WB)) dut_b (
    .clk(clk), .rst(rst_b), .in_row(b_in_row), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_col(b_out_col), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_last(b_out_last),
    .o_dbg_bank_state(b_dbg)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboards: {last, column}
  logic [RA*WA:0] exp_a_q[$];
  logic [RB*WB:0] exp_b_q[$];

  logic [WA-1:0] ma [RA][CA];
  logic [WB-1:0] mb [RB][CB];
  int a_row_idx = 0, a_rows_acc = 0;
  int b_row_idx = 0, b_rows_acc = 0;
  bit b_done = 0;

  // ---------------- driver tasks ----------------
  // Called away from clock edges; leaves in_valid high on return.
  task automatic send_row_a(input logic [CA*WA-1:0] row);
    bit ok = 0;
    logic [RA*WA-1:0] col;
    a_in_row   = row;
    a_in_valid = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      ok = a_in_ready;
      @(posedge clk);
      #1;
    end
    check_val("a_in_accept", ok, 1);
    if (!ok) return;
    for (int c = 0; c < CA; c++) ma[a_row_idx][c] = row[c*WA +: WA];
    a_rows_acc++;
    a_row_idx++;
    if (a_row_idx == RA) begin
      a_row_idx = 0;
      for (int c = 0; c < CA; c++) begin
        col = '0;
        for (int r = 0; r < RA; r++) col[r*WA +: WA] = ma[r][c];
        exp_a_q.push_back({(c == CA - 1), col});
      end
    end
  endtask

  task automatic send_row_b(input logic [CB*WB-1:0] row);
    bit ok = 0;
    logic [RB*WB-1:0] col;
    b_in_row   = row;
    b_in_valid = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      ok = b_in_ready;
      @(posedge clk);
      #1;
    end
    check_val("b_in_accept", ok, 1);
    if (!ok) return;
    for (int c = 0; c < CB; c++) mb[b_row_idx][c] = row[c*WB +: WB];
    b_rows_acc++;
    b_row_idx++;
    if (b_row_idx == RB) begin
      b_row_idx = 0;
      for (int c = 0; c < CB; c++) begin
        col = '0;
        for (int r = 0; r < RB; r++) col[r*WB +: WB] = mb[r][c];
        exp_b_q.push_back({(c == CB - 1), col});
      end
    end
  endtask

  function automatic logic [CA*WA-1:0] load_row(input int r);
    logic [CA*WA-1:0] v = '0;
    for (int c = 0; c < CA; c++) v[c*WA +: WA] = WA'(r * CA + c);
    return v;
  endfunction

  function automatic logic [CB*WB-1:0] rand_row_b();
    logic [CB*WB-1:0] v = '0;
    for (int c = 0; c < CB; c++) v[c*WB +: WB] = WB'($urandom_range(0, 65535));
    return v;
  endfunction

  task automatic wait_drain_a();
    for (int t = 0; t < 300 && exp_a_q.size() != 0; t++) @(posedge clk);
    #1;
    check_val("a_drain", exp_a_q.size(), 0);
    @(posedge clk);
    #1;
    check_val("a_empty_valid", a_out_valid, 0);
  endtask

  task automatic wait_drain_b();
    for (int t = 0; t < 600 && exp_b_q.size() != 0; t++) @(posedge clk);
    #1;
    check_val("b_drain", exp_b_q.size(), 0);
    @(posedge clk);
    #1;
    check_val("b_empty_valid", b_out_valid, 0);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst_a) begin
      if (a_out_valid) begin
        check_val("a_have_exp", exp_a_q.size() != 0, 1);
        if (exp_a_q.size() != 0) begin
          check_val("a_col", a_out_col, exp_a_q[0][RA*WA-1:0]);
          check_val("a_last", a_out_last, exp_a_q[0][RA*WA]);
          if (a_out_ready) void'(exp_a_q.pop_front());
        end
      end else begin
        check_val("a_last_idle", a_out_last, 0);
      end
    end
  end

  logic             b_prev_stall = 1'b0;
  logic [RB*WB-1:0] b_prev_col   = '0;
  always @(negedge clk) begin
    if (rst_b) begin
      b_prev_stall <= 1'b0;
    end else begin
      if (b_prev_stall) begin
        check_val("b_stall_valid", b_out_valid, 1);
        check_val("b_stall_col", b_out_col, b_prev_col);
      end
      if (b_out_valid) begin
        check_val("b_have_exp", exp_b_q.size() != 0, 1);
        if (exp_b_q.size() != 0) begin
          check_val("b_col", b_out_col, exp_b_q[0][RB*WB-1:0]);
          check_val("b_last", b_out_last, exp_b_q[0][RB*WB]);
          if (b_out_ready) void'(exp_b_q.pop_front());
        end
      end
      b_prev_stall <= b_out_valid && !b_out_ready;
      b_prev_col   <= b_out_col;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int gaps;
    bit seen;
    rst_a = 1'b1; rst_b = 1'b1;
    a_in_row = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_row = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", a_in_ready, 1);
    check_val("rst_out_valid", a_out_valid, 0);
    check_val("rst_out_last", a_out_last, 0);
    check_val("rst_out_col", a_out_col, 0);
    check_val("rst_dbg", a_dbg, 0);
    check_val("rst_b_in_ready", b_in_ready, 1);
    check_val("rst_b_out_valid", b_out_valid, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk);
    #1;

    // Load: fixed matrix, 1-cycle latency to the first column
    a_out_ready = 1'b1;
    for (int r = 0; r < RA; r++) send_row_a(load_row(r));
    a_in_valid = 1'b0;
    check_val("load_lat_valid", a_out_valid, 1);
    check_val("load_lat_col", a_out_col, 24'h080400);
    check_val("load_lat_last", a_out_last, 0);
    wait_drain_a();

    // Streaming: 4 back-to-back random matrices
    gaps = 0;
    seen = 0;
    fork
      begin
        for (int i = 0; i < 4 * RA; i++) send_row_a($urandom);
        a_in_valid = 1'b0;
      end
      begin
        for (int t = 0; t < 100 && !seen; t++) begin
          @(negedge clk);
          seen = a_out_valid;
        end
        check_val("stream_start", seen, 1);
        for (int i = 1; i < 4 * CA; i++) begin
          @(negedge clk);
          if (!a_out_valid) gaps++;
        end
        check_val("stream_gaps", gaps, 0);
      end
    join
    wait_drain_a();

    // Back-pressure: 3 matrices offered with out_ready low
    a_out_ready = 1'b0;
    base = a_rows_acc;
    fork
      begin
        for (int r = 0; r < RA; r++) send_row_a(load_row(r));
        for (int i = 0; i < 2 * RA; i++) send_row_a($urandom);
        a_in_valid = 1'b0;
      end
      begin
        repeat (14) @(posedge clk);
        #1;
        check_val("bp_in_ready", a_in_ready, 0);
        check_val("bp_rows_acc", a_rows_acc - base, 6);
        check_val("bp_out_valid", a_out_valid, 1);
        check_val("bp_out_col", a_out_col, 24'h080400);
        check_val("bp_dbg", a_dbg, 4'b1010);
        a_out_ready = 1'b1;
      end
    join
    wait_drain_a();
    check_val("bp_rows_total", a_rows_acc - base, 9);

    // Reset mid-operation: bank0 draining, bank1 holding 2 rows
    a_out_ready = 1'b0;
    for (int i = 0; i < RA + 2; i++) send_row_a($urandom);
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    check_val("mid_dbg", a_dbg, 4'b0111);
    rst_a = 1'b1;
    #1;
    check_val("mid_out_valid", a_out_valid, 0);
    check_val("mid_in_ready", a_in_ready, 1);
    check_val("mid_out_col", a_out_col, 0);
    check_val("mid_out_last", a_out_last, 0);
    check_val("mid_dbg_rst", a_dbg, 0);
    exp_a_q.delete();
    a_row_idx = 0;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    a_out_ready = 1'b1;
    for (int i = 0; i < RA; i++) send_row_a($urandom);
    a_in_valid = 1'b0;
    wait_drain_a();

    // Random valid/ready on the 2x5x16 instance
    fork
      begin
        for (int i = 0; i < 15 * RB; i++) begin
          repeat ($urandom_range(0, 2)) begin
            b_in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send_row_b(rand_row_b());
        end
        b_in_valid = 1'b0;
        b_done = 1;
      end
      begin
        while (!b_done) begin
          b_out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        b_out_ready = 1'b1;
      end
    join
    wait_drain_b();
    check_val("b_rows_total", b_rows_acc, 15 * RB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
